// File: rtl/nios_system_onchip_memory_dma_pkg.sv
// Shared constants and types for the on-chip memory fill/copy engine.
package nios_system_onchip_memory_dma_pkg;

  // Width of the transfer length register and working counter
  localparam int LEN_W = 16;

  // CSR word offsets
  localparam logic [2:0] CSR_SRC    = 3'd0;
  localparam logic [2:0] CSR_DST    = 3'd1;
  localparam logic [2:0] CSR_LEN    = 3'd2;
  localparam logic [2:0] CSR_FILL   = 3'd3;
  localparam logic [2:0] CSR_CTRL   = 3'd4;
  localparam logic [2:0] CSR_STATUS = 3'd5;

  // CTRL bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL_WR,
    ST_CP_RD,
    ST_CP_WR,
    ST_FINISH
  } state_t;

  // Busy covers only the states that own the memory port; FINISH already reads idle
  function automatic logic state_busy(input state_t st);
    return (st == ST_FILL_WR) || (st == ST_CP_RD) || (st == ST_CP_WR);
  endfunction

endpackage

// File: rtl/nios_system_onchip_memory_dma_if.sv
// Bundle of the CSR slave bus and the memory master port of the fill/copy engine.
// "slave" is the engine's view (it is the CSR slave and drives the memory port);
// "master" is the system side (CPU + memory, or a testbench).
interface nios_system_onchip_memory_dma_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic [2:0]          csr_address;
  logic                csr_chipselect;
  logic                csr_read;
  logic                csr_write;
  logic [31:0]         csr_writedata;
  logic [31:0]         csr_readdata;
  logic                irq;

  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W-1:0]   mem_writedata;
  logic                mem_clken;
  logic [DATA_W-1:0]   mem_readdata;

  modport slave (
    input  csr_address, csr_chipselect, csr_read, csr_write, csr_writedata, mem_readdata,
    output csr_readdata, irq,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
  );

  modport master (
    output csr_address, csr_chipselect, csr_read, csr_write, csr_writedata, mem_readdata,
    input  csr_readdata, irq,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken
  );
endinterface

// File: rtl/nios_system_onchip_memory_dma_csr.sv
// CSR register file: configuration registers, busy gating, done W1C and readback.
module nios_system_onchip_memory_dma_csr
  import nios_system_onchip_memory_dma_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        csr_address,
  input  logic              csr_chipselect,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              irq,
  input  logic              busy,
  input  logic              finish,
  output logic              start,
  output logic              start_mode,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [LEN_W-1:0]  len,
  output logic [DATA_W-1:0] fill
);

  logic        wr;
  logic        rd;
  logic        wr_cfg;
  logic        mode;
  logic        irq_en;
  logic        done;
  logic [31:0] rdata;

  assign wr     = csr_chipselect & csr_write;
  assign rd     = csr_chipselect & csr_read;
  // Configuration (including CTRL and therefore start) is frozen while busy
  assign wr_cfg = wr & ~busy;

  assign start      = wr_cfg && (csr_address == CSR_CTRL) && csr_writedata[CTRL_START];
  assign start_mode = csr_writedata[CTRL_MODE];

  assign irq = done & irq_en;

  // Configuration registers, written only when the engine is not busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src    <= '0;
      dst    <= '0;
      len    <= '0;
      fill   <= '0;
      mode   <= 1'b0;
      irq_en <= 1'b0;
    end else if (wr_cfg) begin
      case (csr_address)
        CSR_SRC:  src  <= csr_writedata[ADDR_W-1:0];
        CSR_DST:  dst  <= csr_writedata[ADDR_W-1:0];
        CSR_LEN:  len  <= csr_writedata[LEN_W-1:0];
        CSR_FILL: fill <= csr_writedata[DATA_W-1:0];
        CSR_CTRL: begin
          mode   <= csr_writedata[CTRL_MODE];
          irq_en <= csr_writedata[CTRL_IRQ_EN];
        end
        default: ;
      endcase
    end
  end

  // Done flag: a new start clears it, FINISH sets it and beats a same-cycle W1C
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done <= 1'b0;
    end else if (start) begin
      done <= 1'b0;
    end else if (finish) begin
      done <= 1'b1;
    end else if (wr && (csr_address == CSR_STATUS) && csr_writedata[STAT_DONE]) begin
      done <= 1'b0;
    end
  end

  // Readback mux; start bit and unused offsets read as zero
  always_comb begin
    rdata = '0;
    case (csr_address)
      CSR_SRC:  rdata = 32'(src);
      CSR_DST:  rdata = 32'(dst);
      CSR_LEN:  rdata = 32'(len);
      CSR_FILL: rdata = 32'(fill);
      CSR_CTRL: begin
        rdata[CTRL_MODE]   = mode;
        rdata[CTRL_IRQ_EN] = irq_en;
      end
      CSR_STATUS: begin
        rdata[STAT_BUSY] = busy;
        rdata[STAT_DONE] = done;
      end
      default: ;
    endcase
  end

  // Registered read data, one cycle behind the read strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csr_readdata <= '0;
    end else if (rd) begin
      csr_readdata <= rdata;
    end
  end

endmodule

// File: rtl/nios_system_onchip_memory_dma.sv
// Word-granular fill/copy engine driving the second port of the on-chip memory.
module nios_system_onchip_memory_dma
  import nios_system_onchip_memory_dma_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  nios_system_onchip_memory_dma_if.slave bus
);

  state_t            state;
  logic [ADDR_W-1:0] src_cnt;
  logic [ADDR_W-1:0] dst_cnt;
  logic [LEN_W-1:0]  len_cnt;

  logic              busy;
  logic              finish;
  logic              start;
  logic              start_mode;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] fill;

  assign busy   = state_busy(state);
  assign finish = (state == ST_FINISH);

  nios_system_onchip_memory_dma_csr #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_csr (
    .clk            (clk),
    .reset          (reset),
    .csr_address    (bus.csr_address),
    .csr_chipselect (bus.csr_chipselect),
    .csr_read       (bus.csr_read),
    .csr_write      (bus.csr_write),
    .csr_writedata  (bus.csr_writedata),
    .csr_readdata   (bus.csr_readdata),
    .irq            (bus.irq),
    .busy           (busy),
    .finish         (finish),
    .start          (start),
    .start_mode     (start_mode),
    .src            (src),
    .dst            (dst),
    .len            (len),
    .fill           (fill)
  );

  // Transfer FSM and working counters; FINISH accepts a start just like IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      src_cnt <= '0;
      dst_cnt <= '0;
      len_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_FINISH: begin
          if (start) begin
            src_cnt <= src;
            dst_cnt <= dst;
            len_cnt <= len;
            if (len == '0)      state <= ST_FINISH;
            else if (start_mode) state <= ST_CP_RD;
            else                 state <= ST_FILL_WR;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_FILL_WR: begin
          dst_cnt <= dst_cnt + ADDR_W'(1);
          len_cnt <= len_cnt - LEN_W'(1);
          if (len_cnt == LEN_W'(1)) state <= ST_FINISH;
        end
        ST_CP_RD: begin
          state <= ST_CP_WR;
        end
        ST_CP_WR: begin
          src_cnt <= src_cnt + ADDR_W'(1);
          dst_cnt <= dst_cnt + ADDR_W'(1);
          len_cnt <= len_cnt - LEN_W'(1);
          if (len_cnt == LEN_W'(1)) state <= ST_FINISH;
          else                      state <= ST_CP_RD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory port decoded from registered state/counters; copy data passes straight
  // through from the 1-cycle memory read so a word moves every two cycles
  always_comb begin
    bus.mem_chipselect = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_address    = '0;
    bus.mem_byteenable = '0;
    bus.mem_writedata  = '0;
    case (state)
      ST_FILL_WR: begin
        bus.mem_chipselect = 1'b1;
        bus.mem_write      = 1'b1;
        bus.mem_address    = dst_cnt;
        bus.mem_byteenable = '1;
        bus.mem_writedata  = fill;
      end
      ST_CP_RD: begin
        bus.mem_chipselect = 1'b1;
        bus.mem_address    = src_cnt;
        bus.mem_byteenable = '1;
      end
      ST_CP_WR: begin
        bus.mem_chipselect = 1'b1;
        bus.mem_write      = 1'b1;
        bus.mem_address    = dst_cnt;
        bus.mem_byteenable = '1;
        bus.mem_writedata  = bus.mem_readdata;
      end
      default: ;
    endcase
  end

  assign bus.mem_clken = 1'b1;

endmodule

// File: tb/tb_nios_system_onchip_memory_dma.sv
// Directed testbench for the on-chip memory fill/copy engine.
module tb_nios_system_onchip_memory_dma;
  import nios_system_onchip_memory_dma_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    int          cyc;
    logic [14:0] addr;
    logic        we;
    logic [31:0] data;
  } acc_t;

  acc_t        log_q[$];
  logic [31:0] mem_arr [0:32767];
  logic        pl_en = 1'b0;
  logic [14:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  nios_system_onchip_memory_dma_if bus ();

  nios_system_onchip_memory_dma dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: 1-cycle read latency, bench preload port
  always @(posedge clk) begin
    if (pl_en) mem_arr[pl_addr] <= pl_data;
    else if (bus.mem_chipselect && bus.mem_write) mem_arr[bus.mem_address] <= bus.mem_writedata;
    if (bus.mem_chipselect && !bus.mem_write) bus.mem_readdata <= mem_arr[bus.mem_address];
  end

  // Access log, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.mem_chipselect === 1'b1) begin
      acc_t e;
      e.cyc  = cyc;
      e.addr = bus.mem_address;
      e.we   = bus.mem_write;
      e.data = bus.mem_writedata;
      log_q.push_back(e);
    end
  end

  // All tasks start and end at a falling edge
  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d, output int n);
    bus.csr_chipselect = 1'b1;
    bus.csr_write      = 1'b1;
    bus.csr_address    = a;
    bus.csr_writedata  = d;
    n = cyc;
    @(negedge clk);
    bus.csr_chipselect = 1'b0;
    bus.csr_write      = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    bus.csr_chipselect = 1'b1;
    bus.csr_read       = 1'b1;
    bus.csr_address    = a;
    @(negedge clk);
    bus.csr_chipselect = 1'b0;
    bus.csr_read       = 1'b0;
    d = bus.csr_readdata;
  endtask

  task automatic preload(input logic [14:0] a, input logic [31:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] r;
    int n;
    @(negedge clk);
    checks++; if (bus.mem_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs: got %b want 0", bus.mem_chipselect); end
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", bus.mem_write); end
    checks++; if (bus.mem_address !== 15'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus.mem_address); end
    checks++; if (bus.mem_byteenable !== 4'h0) begin errors++; $display("FAIL rst_be: got %h want 0", bus.mem_byteenable); end
    checks++; if (bus.mem_writedata !== 32'h0) begin errors++; $display("FAIL rst_wd: got %h want 0", bus.mem_writedata); end
    checks++; if (bus.mem_clken !== 1'b1) begin errors++; $display("FAIL rst_clken: got %b want 1", bus.mem_clken); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", bus.irq); end
    checks++; if (bus.csr_readdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.csr_readdata); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    csr_rd(CSR_STATUS, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rst_status: got %h want 0", r); end
    csr_rd(CSR_LEN, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rst_len: got %h want 0", r); end
    // Register widths and unused offsets
    csr_wr(CSR_SRC, 32'hFFFF_FFFF, n);
    csr_wr(CSR_LEN, 32'h0001_2345, n);
    csr_wr(CSR_CTRL, 32'h0000_0006, n);
    csr_wr(3'd6, 32'hDEAD_BEEF, n);
    csr_rd(CSR_SRC, r);
    checks++; if (r !== 32'h0000_7FFF) begin errors++; $display("FAIL reg_src_mask: got %h want 00007fff", r); end
    csr_rd(CSR_LEN, r);
    checks++; if (r !== 32'h0000_2345) begin errors++; $display("FAIL reg_len_mask: got %h want 00002345", r); end
    csr_rd(CSR_CTRL, r);
    checks++; if (r !== 32'h0000_0006) begin errors++; $display("FAIL reg_ctrl: got %h want 00000006", r); end
    csr_rd(3'd6, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reg_addr6: got %h want 0", r); end
    csr_wr(CSR_CTRL, 32'h0, n);
  endtask

  task automatic test_fill_wrap();
    logic [31:0] r;
    logic [14:0] ea;
    int n, s;
    csr_wr(CSR_SRC, 32'h0, n);
    csr_wr(CSR_DST, 32'h7FFE, n);
    csr_wr(CSR_LEN, 32'd4, n);
    csr_wr(CSR_FILL, 32'hA5A5_5A5A, n);
    log_q.delete();
    csr_wr(CSR_CTRL, 32'h1, s);
    wait_cyc(s + 4);
    csr_rd(CSR_STATUS, r);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL fill_busy: got %h want 1", r); end
    csr_rd(CSR_STATUS, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL fill_finish_status: got %h want 0", r); end
    csr_rd(CSR_STATUS, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL fill_done: got %h want 2", r); end
    checks++; if (log_q.size() != 4) begin errors++; $display("FAIL fill_count: got %0d want 4", log_q.size()); end
    for (int i = 0; i < 4; i++) begin
      ea = 15'h7FFE + 15'(i);
      checks++;
      if (i >= log_q.size()) begin
        errors++; $display("FAIL fill_acc%0d: missing access, want addr %h", i, ea);
      end else if (log_q[i].cyc != s + 1 + i || log_q[i].addr !== ea || log_q[i].we !== 1'b1 ||
                   log_q[i].data !== 32'hA5A5_5A5A) begin
        errors++;
        $display("FAIL fill_acc%0d: got cyc %0d addr %h we %b data %h want cyc %0d addr %h we 1 data a5a55a5a",
                 i, log_q[i].cyc - s, log_q[i].addr, log_q[i].we, log_q[i].data, 1 + i, ea);
      end
    end
    checks++; if (mem_arr[15'h0001] !== 32'hA5A5_5A5A) begin errors++; $display("FAIL fill_mem1: got %h want a5a55a5a", mem_arr[15'h0001]); end
  endtask

  task automatic test_copy();
    logic [31:0] r;
    logic [14:0] ea;
    int n, s;
    preload(15'h010, 32'd1);
    preload(15'h011, 32'd2);
    preload(15'h012, 32'd3);
    csr_wr(CSR_SRC, 32'h10, n);
    csr_wr(CSR_DST, 32'h100, n);
    csr_wr(CSR_LEN, 32'd3, n);
    log_q.delete();
    csr_wr(CSR_CTRL, 32'h3, s);
    wait_cyc(s + 6);
    csr_rd(CSR_STATUS, r);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL copy_busy_last: got %h want 1", r); end
    csr_rd(CSR_STATUS, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL copy_finish_status: got %h want 0", r); end
    csr_rd(CSR_STATUS, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL copy_done: got %h want 2", r); end
    checks++; if (log_q.size() != 6) begin errors++; $display("FAIL copy_count: got %0d want 6", log_q.size()); end
    for (int i = 0; i < 6; i++) begin
      ea = (i % 2 == 0) ? 15'h010 + 15'(i / 2) : 15'h100 + 15'(i / 2);
      checks++;
      if (i >= log_q.size()) begin
        errors++; $display("FAIL copy_acc%0d: missing access, want addr %h", i, ea);
      end else if (log_q[i].cyc != s + 1 + i || log_q[i].addr !== ea || log_q[i].we !== 1'(i % 2) ||
                   (i % 2 == 1 && log_q[i].data !== 32'(i / 2 + 1))) begin
        errors++;
        $display("FAIL copy_acc%0d: got cyc %0d addr %h we %b data %h want cyc %0d addr %h we %0d",
                 i, log_q[i].cyc - s, log_q[i].addr, log_q[i].we, log_q[i].data, 1 + i, ea, i % 2);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_arr[15'h100 + 15'(i)] !== 32'(i + 1)) begin
        errors++; $display("FAIL copy_mem%0d: got %h want %h", i, mem_arr[15'h100 + 15'(i)], 32'(i + 1));
      end
    end
  endtask

  task automatic test_len_zero();
    logic [31:0] r;
    int n, s;
    csr_wr(CSR_LEN, 32'd0, n);
    for (int m = 0; m < 2; m++) begin
      log_q.delete();
      csr_wr(CSR_CTRL, (m == 1) ? 32'h3 : 32'h1, s);
      csr_rd(CSR_STATUS, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL len0_m%0d_finish: got %h want 0", m, r); end
      csr_rd(CSR_STATUS, r);
      checks++; if (r !== 32'h2) begin errors++; $display("FAIL len0_m%0d_done: got %h want 2", m, r); end
      wait_cyc(s + 5);
      checks++; if (log_q.size() != 0) begin errors++; $display("FAIL len0_m%0d_access: got %0d accesses want 0", m, log_q.size()); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] r;
    int n, s;
    csr_wr(CSR_DST, 32'h200, n);
    csr_wr(CSR_LEN, 32'd8, n);
    csr_wr(CSR_FILL, 32'h1234_5678, n);
    log_q.delete();
    csr_wr(CSR_CTRL, 32'h1, s);
    csr_wr(CSR_DST, 32'h300, n);
    csr_wr(CSR_CTRL, 32'h3, n);
    csr_wr(CSR_LEN, 32'd2, n);
    wait_cyc(s + 12);
    checks++; if (log_q.size() != 8) begin errors++; $display("FAIL busy_count: got %0d want 8", log_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= log_q.size()) begin
        errors++; $display("FAIL busy_acc%0d: missing access", i);
      end else if (log_q[i].cyc != s + 1 + i || log_q[i].addr !== 15'h200 + 15'(i) || log_q[i].we !== 1'b1) begin
        errors++;
        $display("FAIL busy_acc%0d: got cyc %0d addr %h we %b want cyc %0d addr %h we 1",
                 i, log_q[i].cyc - s, log_q[i].addr, log_q[i].we, 1 + i, 15'h200 + 15'(i));
      end
    end
    csr_rd(CSR_DST, r);
    checks++; if (r !== 32'h200) begin errors++; $display("FAIL busy_dst: got %h want 00000200", r); end
    csr_rd(CSR_LEN, r);
    checks++; if (r !== 32'd8) begin errors++; $display("FAIL busy_len: got %h want 00000008", r); end
    csr_rd(CSR_CTRL, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL busy_ctrl: got %h want 0", r); end
  endtask

  task automatic test_irq();
    logic [31:0] r;
    int n, s;
    csr_wr(CSR_DST, 32'h50, n);
    csr_wr(CSR_LEN, 32'd1, n);
    csr_wr(CSR_FILL, 32'hCAFE_F00D, n);
    csr_wr(CSR_CTRL, 32'h5, s);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_n1: got %b want 0", bus.irq); end
    wait_cyc(s + 2);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_n2: got %b want 0", bus.irq); end
    wait_cyc(s + 3);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_n3: got %b want 1", bus.irq); end
    checks++; if (mem_arr[15'h50] !== 32'hCAFE_F00D) begin errors++; $display("FAIL irq_mem: got %h want cafef00d", mem_arr[15'h50]); end
    csr_wr(CSR_STATUS, 32'h2, n);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_w1c: got %b want 0", bus.irq); end
    csr_rd(CSR_STATUS, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL irq_status: got %h want 0", r); end
    // W1C landing in the FINISH cycle loses to the done set
    csr_wr(CSR_CTRL, 32'h5, s);
    wait_cyc(s + 2);
    csr_wr(CSR_STATUS, 32'h2, n);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b want 1", bus.irq); end
    csr_wr(CSR_STATUS, 32'h2, n);
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_w1c2: got %b want 0", bus.irq); end
  endtask

  task automatic test_reset_mid_copy();
    logic [31:0] r;
    int n, s;
    preload(15'h020, 32'h11);
    preload(15'h021, 32'h22);
    csr_wr(CSR_SRC, 32'h20, n);
    csr_wr(CSR_DST, 32'h400, n);
    csr_wr(CSR_LEN, 32'd10, n);
    log_q.delete();
    csr_wr(CSR_CTRL, 32'h3, s);
    wait_cyc(s + 3);
    checks++; if (bus.mem_chipselect !== 1'b1 || bus.mem_write !== 1'b0) begin
      errors++; $display("FAIL rmid_active: got cs %b we %b want cs 1 we 0", bus.mem_chipselect, bus.mem_write); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.mem_chipselect !== 1'b0) begin errors++; $display("FAIL rmid_cs: got %b want 0", bus.mem_chipselect); end
    checks++; if (bus.mem_write !== 1'b0 || bus.mem_byteenable !== 4'h0) begin
      errors++; $display("FAIL rmid_we_be: got we %b be %h want 0 0", bus.mem_write, bus.mem_byteenable); end
    checks++; if (bus.mem_address !== 15'h0 || bus.mem_writedata !== 32'h0) begin
      errors++; $display("FAIL rmid_addr_wd: got %h %h want 0 0", bus.mem_address, bus.mem_writedata); end
    checks++; if (bus.mem_clken !== 1'b1) begin errors++; $display("FAIL rmid_clken: got %b want 1", bus.mem_clken); end
    checks++; if (log_q.size() != 3) begin errors++; $display("FAIL rmid_pre_count: got %0d want 3", log_q.size()); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (log_q.size() != 3) begin errors++; $display("FAIL rmid_post_count: got %0d want 3", log_q.size()); end
    checks++; if (mem_arr[15'h400] !== 32'h11) begin errors++; $display("FAIL rmid_mem: got %h want 00000011", mem_arr[15'h400]); end
    csr_rd(CSR_STATUS, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rmid_status: got %h want 0", r); end
    csr_rd(CSR_SRC, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rmid_src: got %h want 0", r); end
  endtask

  initial begin
    bus.csr_address    = '0;
    bus.csr_chipselect = 1'b0;
    bus.csr_read       = 1'b0;
    bus.csr_write      = 1'b0;
    bus.csr_writedata  = '0;
    bus.mem_readdata   = '0;
    test_reset();
    test_fill_wrap();
    test_copy();
    test_len_zero();
    test_busy_ignore();
    test_irq();
    test_reset_mid_copy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
